// File: rtl/fifo2axi_burst_writer.sv
// Write-side AXI4 burst master: drains a first-word-fall-through FIFO into a
// ring region [ADDR_BEGIN, ADDR_END) of MIG DDR3 memory. Bursts are clipped
// at the FIFO fill level, the ring end and 4KB page boundaries. A flush pulse
// lets short residue bursts go out.
module fifo2axi_burst_writer #(
    parameter int DATA_W     = 128,
    parameter int ADDR_W     = 28,
    parameter int ID_W       = 4,
    parameter int AXI_ID     = 0,
    parameter int AXI_LEN    = 31,
    parameter int ADDR_BEGIN = 0,
    parameter int ADDR_END   = 2048,
    parameter int CNT_W      = 9
) (
    input  logic                ui_clk,
    input  logic                ui_clk_sync_rst,
    input  logic                init_calib_complete,
    input  logic                addr_clr,
    input  logic                flush,
    output logic                fifo_rdreq,
    input  logic [DATA_W-1:0]   fifo_rddata,
    input  logic                fifo_empty,
    input  logic [CNT_W-1:0]    fifo_rd_cnt,
    input  logic                fifo_rst_busy,
    output logic [ID_W-1:0]     m_axi_awid,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    output logic                m_axi_awlock,
    output logic [3:0]          m_axi_awcache,
    output logic [2:0]          m_axi_awprot,
    output logic [3:0]          m_axi_awqos,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [ID_W-1:0]     m_axi_bid,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic                busy,
    output logic                burst_done,
    output logic                bresp_err
);

    localparam int BPB       = DATA_W / 8;
    localparam int SHIFT     = $clog2(BPB);
    localparam int MAX_BEATS = AXI_LEN + 1;
    localparam logic [ADDR_W:0]   END_A   = (ADDR_W+1)'(ADDR_END);
    localparam logic [ADDR_W-1:0] BEGIN_A = ADDR_W'(ADDR_BEGIN);

    typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W, ST_B} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [7:0]        awlen_reg;
    logic [7:0]        beat_reg;
    logic              flush_pend_reg;
    logic              clr_pend_reg;
    logic              bresp_err_reg;

    logic [ADDR_W:0]   ring_room;
    logic [12:0]       page_room;
    logic [8:0]        beats_calc;
    logic [ADDR_W:0]   burst_bytes;
    logic [ADDR_W:0]   addr_sum;
    logic              start_ok;

    // The write ID is not needed: only one burst is ever outstanding.
    logic unused_bid;
    assign unused_bid = ^m_axi_bid;

    // Room left (in beats) before the ring end and before the next 4KB page.
    assign ring_room = (END_A - {1'b0, wr_addr_reg}) >> SHIFT;
    assign page_room = (13'd4096 - {1'b0, wr_addr_reg[11:0]}) >> SHIFT;

    // Burst length: smallest of FIFO fill, max burst, ring room, page room.
    always_comb begin
        beats_calc = 9'(MAX_BEATS);
        if (32'(fifo_rd_cnt) < 32'(beats_calc)) beats_calc = 9'(fifo_rd_cnt);
        if (ring_room < (ADDR_W+1)'(beats_calc)) beats_calc = 9'(ring_room);
        if (page_room < 13'(beats_calc))         beats_calc = 9'(page_room);
    end

    // A zero-length result (stale count with a non-empty flag) never starts a burst.
    assign start_ok = (state_reg == ST_IDLE) && init_calib_complete && !fifo_rst_busy &&
                      !addr_clr && (beats_calc != 9'd0) &&
                      ((32'(fifo_rd_cnt) >= 32'(MAX_BEATS)) || (flush_pend_reg && !fifo_empty));

    assign burst_bytes = ((ADDR_W+1)'(awlen_reg) + (ADDR_W+1)'(1)) << SHIFT;
    assign addr_sum    = {1'b0, wr_addr_reg} + burst_bytes;

    // State register.
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) state_reg <= ST_IDLE;
        else                 state_reg <= state_next;
    end

    // Next-state logic and channel valid/ready strobes.
    always_comb begin
        state_next    = state_reg;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        case (state_reg)
            ST_IDLE: if (start_ok) state_next = ST_AW;
            ST_AW: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) state_next = ST_W;
            end
            ST_W: begin
                m_axi_wvalid = 1'b1;
                if (m_axi_wready && m_axi_wlast) state_next = ST_B;
            end
            ST_B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Write pointer, burst length, beat counter and the pending flags.
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            wr_addr_reg    <= BEGIN_A;
            awlen_reg      <= 8'd0;
            beat_reg       <= 8'd0;
            flush_pend_reg <= 1'b0;
            clr_pend_reg   <= 1'b0;
            bresp_err_reg  <= 1'b0;
        end else begin
            // A new flush request outranks the empty-FIFO clear.
            if (flush)
                flush_pend_reg <= 1'b1;
            else if (state_reg == ST_IDLE && fifo_empty)
                flush_pend_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    clr_pend_reg <= 1'b0;
                    if (addr_clr)
                        wr_addr_reg <= BEGIN_A;
                    else if (start_ok)
                        awlen_reg <= 8'(beats_calc - 9'd1);
                end
                ST_AW: begin
                    if (addr_clr) clr_pend_reg <= 1'b1;
                    if (m_axi_awready) beat_reg <= 8'd0;
                end
                ST_W: begin
                    if (addr_clr) clr_pend_reg <= 1'b1;
                    if (m_axi_wready) beat_reg <= beat_reg + 8'd1;
                end
                ST_B: begin
                    if (m_axi_bvalid) begin
                        bresp_err_reg <= bresp_err_reg | (m_axi_bresp != 2'b00);
                        clr_pend_reg  <= 1'b0;
                        if (clr_pend_reg || addr_clr || addr_sum >= END_A)
                            wr_addr_reg <= BEGIN_A;
                        else
                            wr_addr_reg <= addr_sum[ADDR_W-1:0];
                    end else if (addr_clr) begin
                        clr_pend_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The pointer is frozen for the whole burst, so it doubles as awaddr.
    assign m_axi_awaddr  = wr_addr_reg;
    assign m_axi_awlen   = awlen_reg;
    assign m_axi_awid    = ID_W'(AXI_ID);
    assign m_axi_awsize  = 3'(SHIFT);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'b0000;
    assign m_axi_wdata   = fifo_rddata;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = (state_reg == ST_W) && (beat_reg == awlen_reg);
    assign fifo_rdreq    = m_axi_wvalid & m_axi_wready;
    assign busy          = (state_reg != ST_IDLE);
    assign burst_done    = (state_reg == ST_B) && m_axi_bvalid;
    assign bresp_err     = bresp_err_reg;

endmodule

// File: tb/tb_fifo2axi_burst_writer.sv
// Bench for fifo2axi_burst_writer: queue-based FIFO and AXI slave, a
// burst-level reference model checked every cycle, directed ring/page/flush
// scenarios pinned with literal addresses, then randomized traffic.
`timescale 1ns/1ps
module tb_fifo2axi_burst_writer;

    localparam int DATA_W     = 128;
    localparam int ADDR_W     = 28;
    localparam int ID_W       = 4;
    localparam int AXI_ID     = 5;
    localparam int AXI_LEN    = 31;
    localparam int ADDR_BEGIN = 'h40;
    localparam int ADDR_END   = 'h2100;
    localparam int CNT_W      = 9;
    localparam int BPB        = DATA_W / 8;

    logic                ui_clk = 1'b0;
    logic                ui_clk_sync_rst;
    logic                init_calib_complete;
    logic                addr_clr;
    logic                flush;
    logic                fifo_rdreq;
    logic [DATA_W-1:0]   fifo_rddata;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_rd_cnt;
    logic                fifo_rst_busy;
    logic [ID_W-1:0]     m_axi_awid;
    logic [ADDR_W-1:0]   m_axi_awaddr;
    logic [7:0]          m_axi_awlen;
    logic [2:0]          m_axi_awsize;
    logic [1:0]          m_axi_awburst;
    logic                m_axi_awlock;
    logic [3:0]          m_axi_awcache;
    logic [2:0]          m_axi_awprot;
    logic [3:0]          m_axi_awqos;
    logic                m_axi_awvalid;
    logic                m_axi_awready;
    logic [DATA_W-1:0]   m_axi_wdata;
    logic [DATA_W/8-1:0] m_axi_wstrb;
    logic                m_axi_wlast;
    logic                m_axi_wvalid;
    logic                m_axi_wready;
    logic [ID_W-1:0]     m_axi_bid;
    logic [1:0]          m_axi_bresp;
    logic                m_axi_bvalid;
    logic                m_axi_bready;
    logic                busy;
    logic                burst_done;
    logic                bresp_err;

    always #5 ui_clk = ~ui_clk;

    fifo2axi_burst_writer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .AXI_ID(AXI_ID),
        .AXI_LEN(AXI_LEN), .ADDR_BEGIN(ADDR_BEGIN), .ADDR_END(ADDR_END), .CNT_W(CNT_W)
    ) dut (
        .ui_clk(ui_clk), .ui_clk_sync_rst(ui_clk_sync_rst),
        .init_calib_complete(init_calib_complete), .addr_clr(addr_clr), .flush(flush),
        .fifo_rdreq(fifo_rdreq), .fifo_rddata(fifo_rddata), .fifo_empty(fifo_empty),
        .fifo_rd_cnt(fifo_rd_cnt), .fifo_rst_busy(fifo_rst_busy),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .busy(busy), .burst_done(burst_done), .bresp_err(bresp_err)
    );

    int total = 0;
    int bad   = 0;

    // FIFO contents as seen by the DUT, and the stream the memory must receive.
    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] ref_q[$];

    // Reference model: phase 0 idle, 1 address, 2 data, 3 response.
    int ph, m_wr, m_len, m_beat;
    bit m_fp, m_clr, m_err;

    // Slave / stimulus knobs and observation logs.
    int         b_pend   = 0;
    int         rdy_pct  = 100;
    int         push_pct = 100;
    int         push_left = 0;
    logic [1:0] bresp_val = 2'b00;
    int         aw_addr_log[$];
    int         aw_len_log[$];
    int         beats_log[$];
    int         beats_cur = 0;
    int         done_cnt  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty  = (fifo_q.size() == 0);
        fifo_rd_cnt = (fifo_q.size() > 511) ? 9'd511 : 9'(fifo_q.size());
        fifo_rddata = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic model_reset();
        ph = 0; m_wr = ADDR_BEGIN; m_len = 0; m_beat = 0;
        m_fp = 0; m_clr = 0; m_err = 0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance.
    task automatic step();
        logic [DATA_W-1:0] w;
        logic [DATA_W-1:0] exp_w;
        int  cnt, beats, nxt;
        bit  pop;
        m_axi_awready = ($urandom_range(99) < rdy_pct);
        m_axi_wready  = ($urandom_range(99) < rdy_pct);
        m_axi_bvalid  = (b_pend > 0) && ($urandom_range(99) < rdy_pct);
        m_axi_bresp   = m_axi_bvalid ? bresp_val : 2'b00;
        m_axi_bid     = ID_W'(AXI_ID);
        if (push_left > 0 && fifo_q.size() < 480 && $urandom_range(99) < push_pct) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            fifo_q.push_back(w);
            ref_q.push_back(w);
            push_left--;
        end
        drive_fifo();
        #1;
        cnt = (fifo_q.size() > 511) ? 511 : fifo_q.size();

        chk("busy",       128'(busy),          128'(ph != 0));
        chk("awvalid",    128'(m_axi_awvalid), 128'(ph == 1));
        chk("wvalid",     128'(m_axi_wvalid),  128'(ph == 2));
        chk("bready",     128'(m_axi_bready),  128'(ph == 3));
        chk("burst_done", 128'(burst_done),    128'(ph == 3 && m_axi_bvalid));
        chk("fifo_rdreq", 128'(fifo_rdreq),    128'(ph == 2 && m_axi_wready));
        chk("bresp_err",  128'(bresp_err),     128'(m_err));
        if (ph == 1) begin
            chk("awaddr", 128'(m_axi_awaddr), 128'(m_wr));
            chk("awlen",  128'(m_axi_awlen),  128'(m_len));
        end
        if (ph == 2) chk("wlast", 128'(m_axi_wlast), 128'(m_beat == m_len));
        if (ph == 1 && m_axi_awready)
            chk("aw_const", 128'({m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awlock,
                                  m_axi_awcache, m_axi_awprot, m_axi_awqos}),
                128'({4'd5, 3'd4, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000}));
        if (ph == 2 && m_axi_wready) begin
            exp_w = (ref_q.size() != 0) ? ref_q.pop_front() : 'x;
            chk("wdata", m_axi_wdata, exp_w);
            chk("wstrb", 128'(m_axi_wstrb), 128'(16'hFFFF));
        end

        // Observation logs taken from the DUT's own handshakes.
        if (m_axi_awvalid && m_axi_awready) begin
            aw_addr_log.push_back(int'(m_axi_awaddr));
            aw_len_log.push_back(int'(m_axi_awlen));
        end
        if (m_axi_wvalid && m_axi_wready) begin
            beats_cur++;
            if (m_axi_wlast) begin
                beats_log.push_back(beats_cur);
                beats_cur = 0;
                b_pend++;
            end
        end
        if (m_axi_bvalid && m_axi_bready) begin
            b_pend--;
            done_cnt++;
            $display("burst %0d: addr=0x%0h len=%0d bresp=%0d", done_cnt,
                     aw_addr_log[aw_addr_log.size()-1], aw_len_log[aw_len_log.size()-1], m_axi_bresp);
        end

        // Advance the reference model from the rules for this cycle's inputs.
        case (ph)
            0: begin
                if (addr_clr) m_wr = ADDR_BEGIN;
                else if (init_calib_complete && !fifo_rst_busy &&
                         (cnt >= AXI_LEN + 1 || (m_fp && cnt > 0))) begin
                    beats = AXI_LEN + 1;
                    if (cnt < beats) beats = cnt;
                    if ((ADDR_END - m_wr) / BPB < beats) beats = (ADDR_END - m_wr) / BPB;
                    if ((4096 - (m_wr % 4096)) / BPB < beats) beats = (4096 - (m_wr % 4096)) / BPB;
                    m_len = beats - 1;
                    ph = 1;
                end
            end
            1: begin
                if (addr_clr) m_clr = 1;
                if (m_axi_awready) begin ph = 2; m_beat = 0; end
            end
            2: begin
                if (addr_clr) m_clr = 1;
                if (m_axi_wready) begin
                    if (m_beat == m_len) ph = 3;
                    else m_beat++;
                end
            end
            default: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) m_err = 1;
                    nxt = m_wr + (m_len + 1) * BPB;
                    m_wr = (m_clr || addr_clr || nxt >= ADDR_END) ? ADDR_BEGIN : nxt;
                    m_clr = 0;
                    ph = 0;
                end else if (addr_clr) m_clr = 1;
            end
        endcase
        if (flush) m_fp = 1;
        else if (ph_was_idle_empty(cnt)) m_fp = 0;

        pop = fifo_rdreq;
        @(posedge ui_clk);
        #1;
        if (pop) begin
            chk("fifo_pop_nonempty", 128'(fifo_q.size() != 0), 128'(1));
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        end
    endtask

    // flush_pend clears when the machine sits idle on an empty FIFO; the idle
    // phase is the one this cycle started in, tracked separately below.
    bit ph_idle_at_start;
    function automatic bit ph_was_idle_empty(input int cnt);
        return ph_idle_at_start && (cnt == 0);
    endfunction

    task automatic tick();
        ph_idle_at_start = (ph == 0);
        step();
    endtask

    task automatic run_until(input int target, input int budget, input string name);
        int n = 0;
        while (!(done_cnt >= target && ph == 0) && n < budget) begin
            tick();
            n++;
        end
        chk({"timeout_", name}, 128'(n < budget), 128'(1));
    endtask

    initial begin
        ui_clk_sync_rst = 1'b1;
        init_calib_complete = 1'b1;
        addr_clr = 1'b0; flush = 1'b0; fifo_rst_busy = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
        m_axi_bresp = 2'b00; m_axi_bid = '0;
        drive_fifo();
        repeat (3) @(posedge ui_clk);
        #1;
        chk("rst_outputs", 128'({busy, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                                 fifo_rdreq, burst_done, bresp_err}), 128'(0));
        ui_clk_sync_rst = 1'b0;
        model_reset();

        // Full burst from the ring start.
        push_left = 32;
        run_until(1, 300, "first_burst");
        chk("b1_addr",  128'(aw_addr_log.size() > 0 ? aw_addr_log[0] : -1), 128'('h40));
        chk("b1_len",   128'(aw_len_log.size()  > 0 ? aw_len_log[0]  : -1), 128'(31));
        chk("b1_beats", 128'(beats_log.size()   > 0 ? beats_log[0]   : -1), 128'(32));

        // Residue below a full burst waits for flush.
        push_left = 5;
        repeat (20) tick();
        chk("no_aw_without_flush", 128'(aw_addr_log.size()), 128'(1));
        flush = 1'b1; tick(); flush = 1'b0;
        run_until(2, 200, "flush_burst");
        chk("b2_addr",  128'(aw_addr_log.size() > 1 ? aw_addr_log[1] : -1), 128'('h240));
        chk("b2_len",   128'(aw_len_log.size()  > 1 ? aw_len_log[1]  : -1), 128'(4));
        chk("b2_beats", 128'(beats_log.size()   > 1 ? beats_log[1]   : -1), 128'(5));
        repeat (3) tick();
        push_left = 5;
        repeat (20) tick();
        chk("flush_cleared", 128'(aw_addr_log.size()), 128'(2));

        // addr_clr during the data phase: burst completes, next one restarts.
        push_left = 27;
        begin
            int n = 0;
            while (ph != 2 && n < 200) begin tick(); n++; end
            chk("timeout_reach_w", 128'(n < 200), 128'(1));
        end
        addr_clr = 1'b1; tick(); addr_clr = 1'b0;
        run_until(3, 300, "clr_burst");
        chk("b3_addr", 128'(aw_addr_log.size() > 2 ? aw_addr_log[2] : -1), 128'('h290));
        chk("b3_len",  128'(aw_len_log.size()  > 2 ? aw_len_log[2]  : -1), 128'(31));

        // 4KB clip then ring-end clip and wrap, with random stalls.
        rdy_pct = 70;
        push_left = 556;
        run_until(21, 6000, "ring_walk");
        chk("b4_addr",  128'(aw_addr_log.size() > 3  ? aw_addr_log[3]  : -1), 128'('h40));
        chk("b11_addr", 128'(aw_addr_log.size() > 10 ? aw_addr_log[10] : -1), 128'('hE40));
        chk("b11_len",  128'(aw_len_log.size()  > 10 ? aw_len_log[10]  : -1), 128'(27));
        chk("b12_addr", 128'(aw_addr_log.size() > 11 ? aw_addr_log[11] : -1), 128'('h1000));
        chk("b12_len",  128'(aw_len_log.size()  > 11 ? aw_len_log[11]  : -1), 128'(31));
        chk("b20_addr", 128'(aw_addr_log.size() > 19 ? aw_addr_log[19] : -1), 128'('h2000));
        chk("b20_len",  128'(aw_len_log.size()  > 19 ? aw_len_log[19]  : -1), 128'(15));
        chk("b21_addr", 128'(aw_addr_log.size() > 20 ? aw_addr_log[20] : -1), 128'('h40));

        // Error response is sticky.
        chk("err_before", 128'(bresp_err), 128'(0));
        bresp_val = 2'b10;
        push_left = 32;
        run_until(22, 600, "err_burst");
        bresp_val = 2'b00;
        chk("err_set", 128'(bresp_err), 128'(1));
        push_left = 32;
        run_until(23, 600, "after_err");
        chk("err_held", 128'(bresp_err), 128'(1));

        // Randomized traffic.
        rdy_pct = 60;
        push_pct = 50;
        push_left = 100000;
        for (int i = 0; i < 3000; i++) begin
            flush = ($urandom_range(59) == 0);
            addr_clr = ($urandom_range(149) == 0);
            init_calib_complete = ($urandom_range(19) != 0);
            fifo_rst_busy = ($urandom_range(29) == 0);
            bresp_val = ($urandom_range(9) == 0) ? 2'b10 : 2'b00;
            tick();
        end
        push_left = 0;
        addr_clr = 1'b0; init_calib_complete = 1'b1; fifo_rst_busy = 1'b0; bresp_val = 2'b00;
        flush = 1'b1; tick(); flush = 1'b0;
        begin
            int n = 0;
            while (!(fifo_q.size() == 0 && ph == 0) && n < 5000) begin tick(); n++; end
            chk("timeout_drain", 128'(n < 5000), 128'(1));
        end
        chk("drained", 128'(fifo_q.size()), 128'(0));
        chk("ref_drained", 128'(ref_q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
